paged_cache_controller: RTL and testbench
=========================================

Name: paged_cache_controller

Overview:
Parametrised successor to the cached external-memory controller. Maps a byte-addressed virtual space onto a local SRAM organised as 2^PAGE_INDEX_ADDRESS_SIZE direct-mapped pages. Adds per-page tag, valid and dirty tracking, automatic write-back eviction, a flush-all scan, invalidate-all, and a miss counter. Sits between the bus-side memory port and the QSPI word-stream device; the SRAM data path is wired externally (QSPI read data to SRAM write data, SRAM read data to QSPI write data).

Parameters:
ADDRESS_SIZE, 24, virtual byte-address width
SRAM_ADDRESS_SIZE, 9, SRAM word-address width; total cache is 2^9 words
PAGE_INDEX_ADDRESS_SIZE, 4, page-index width; 16 pages of 2^(9-4)=32 words
WRITE_BACK, 1, 1 = writes allowed and dirty pages flushed; 0 = read-only cache, writes rejected
MISS_COUNT_SIZE, 16, miss counter width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-low
bus_enable  in  1  access request, held until bus_ready or bus_error
bus_write_enable  in  1  request is a write
bus_address  in  ADDRESS_SIZE  virtual byte address
bus_ready  out  1  hit; SRAM may be accessed this cycle (combinational)
bus_error  out  1  write rejected (WRITE_BACK=0), combinational
bus_physical_address  out  SRAM_ADDRESS_SIZE  bus_address[SRAM_ADDRESS_SIZE+1:2]
flush_all  in  1  pulse: write back all dirty pages
invalidate_all  in  1  pulse: clear all valid/dirty bits
busy  out  1  FSM not in IDLE or request pending
miss_count  out  MISS_COUNT_SIZE  wrapping miss counter
mem_initialised  in  1  QSPI device ready
mem_busy  in  1  QSPI device mid-operation
mem_word_complete  in  1  one-cycle pulse: current word done
mem_address  out  ADDRESS_SIZE  page base byte address
mem_change_address  out  1  one-cycle pulse: load mem_address
mem_request_data  out  1  read a word (held until word_complete)
mem_store_data  out  1  write a word (held until word_complete)
sram_enable  out  1  controller-port SRAM select
sram_write_enable  out  1  controller-port write
sram_address  out  SRAM_ADDRESS_SIZE  {page index, word counter}

Behaviour:
- Address split (defaults): [1:0] byte, [6:2] word-in-page, [10:7] index, [23:11] tag (TAG = ADDRESS_SIZE-2-SRAM_ADDRESS_SIZE bits).
- Reset: all valid/dirty cleared, tags 0, miss_count 0, state IDLE, pending flags 0. Every output is 0 except bus_physical_address, which follows its input. A reset mid-transfer abandons the transfer; the cache is empty afterwards.
- Hit = valid[idx] && tag[idx]==addr tag && state IDLE && no pending flush/invalidate.
- Read hit: bus_ready=1 in the same cycle.
- Write hit with WRITE_BACK=1: bus_ready=1 in the same cycle, and dirty[idx] is set at the clock edge.
- Any write with WRITE_BACK=0: bus_error=1 and bus_ready=0; no state change and no miss is counted.
- Miss, IDLE: latch idx/new tag; miss_count+1 (wraps). If valid&&dirty go to FLUSH_START, else go to LOAD_START.
- FLUSH_START / LOAD_START: wait until mem_initialised=1 && mem_busy=0, then pulse mem_change_address for 1 cycle with mem_address = {old or new tag, idx, zero word, 2'b00}. Word counter = 0.
- FLUSH_READ: sram_enable=1, we=0, sram_address={idx,ctr}; lasts 1 cycle (SRAM read latency), then FLUSH_WORD.
- FLUSH_WORD: SRAM read held; mem_store_data=1 until mem_word_complete.
  - On completion: ctr+1, back to FLUSH_READ.
  - After the last word: dirty[idx]=0. Go to LOAD_START on a miss, or back to SCAN on flush_all.
- LOAD_WORD: mem_request_data=1 until mem_word_complete. In the completion cycle: sram_enable=1, we=1, sram_address={idx,ctr}; ctr+1.
  - After the last word: tag[idx]=new, valid=1, dirty=0, go to IDLE. The request hits the next cycle.
- flush_all: latched while busy. In IDLE it takes priority over a miss. SCAN visits idx 0..PAGE_COUNT-1, one cycle per clean page, and flushes each dirty page. Valid bits are kept; afterwards IDLE.
- invalidate_all: latched. Executes in IDLE in 1 cycle, after any pending flush_all. Dirty data is discarded.
- The word counter wraps at 2^(SRAM_ADDRESS_SIZE-PAGE_INDEX_ADDRESS_SIZE); the last word is ctr = all-ones.
- busy=1 whenever state!=IDLE or a flush/invalidate is pending.

Decomposition:
- Shared package: derived widths (TAG_SIZE, PAGE_DATA_ADDRESS_SIZE, PAGE_COUNT) and the state encoding (IDLE, SCAN, FLUSH_START, FLUSH_READ, FLUSH_WORD, LOAD_START, LOAD_WORD).
- One sub-module, cache_tag_store: valid/dirty/tag arrays with combinational hit lookup, plus set/clear ports and bulk invalidate.

Test Plan:
1. Read 0x000100 after reset -> change_address with mem_address 0x000100, 32 request_data words, SRAM writes 0x040..0x05F, then bus_ready with phys 0x040; miss_count=1.
2. Write 0x000104 (hit) then read 0x000904 -> bus_ready on the write; then flush of 32 words at base 0x000100, load from 0x000900, bus_ready with phys 0x041.
3. WRITE_BACK=0, write 0x000100 -> bus_error=1, bus_ready=0, no mem activity, miss_count unchanged.
4. Pages 3 and 7 dirty, pulse flush_all -> exactly two flushes at 0x000180 and 0x000380, busy high throughout, then re-reads of both pages hit. Then invalidate_all -> the same read misses.
5. Reset asserted during LOAD_WORD word 10 -> outputs at reset values immediately; re-reading the same page misses and reloads all 32 words.
6. mem_initialised=0 on a miss -> no change_address until it rises; bus_ready only after the load completes.

Source files
------------

// File: rtl/paged_cache_controller_pkg.sv
// Shared widths and FSM encoding for the paged cache controller and its tag store.
package paged_cache_controller_pkg;

  function automatic int unsigned tagSize(int unsigned addressSize, int unsigned sramAddressSize);
    return addressSize - 2 - sramAddressSize;
  endfunction

  function automatic int unsigned pageDataAddressSize(int unsigned sramAddressSize,
                                                      int unsigned pageIndexAddressSize);
    return sramAddressSize - pageIndexAddressSize;
  endfunction

  function automatic int unsigned pageCount(int unsigned pageIndexAddressSize);
    return 32'd1 << pageIndexAddressSize;
  endfunction

  localparam int unsigned TAG_SIZE = tagSize(24, 9);
  localparam int unsigned PAGE_DATA_ADDRESS_SIZE = pageDataAddressSize(9, 4);
  localparam int unsigned PAGE_COUNT = pageCount(4);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StFlushStart,
    StFlushRead,
    StFlushWord,
    StLoadStart,
    StLoadWord
  } cacheState_t;

endpackage

// File: rtl/paged_cache_controller_tag_store.sv
// Per-page valid/dirty/tag storage: combinational bus lookup plus a second read port for the FSM page.
module cache_tag_store
  import paged_cache_controller_pkg::*;
#(
  parameter int unsigned TagSize   = 13,
  parameter int unsigned IndexSize = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IndexSize-1:0] lookupIndex_i,
  input  logic [TagSize-1:0]   lookupTag_i,
  output logic                 lookupMatch_o,
  output logic                 lookupDirty_o,
  input  logic [IndexSize-1:0] pageIndex_i,
  output logic                 pageDirty_o,
  output logic [TagSize-1:0]   pageTag_o,
  input  logic                 setDirty_i,
  input  logic                 clearDirty_i,
  input  logic                 fill_i,
  input  logic [TagSize-1:0]   fillTag_i,
  input  logic                 invalidateAll_i
);

  localparam int unsigned PageCount = pageCount(IndexSize);

  logic [PageCount-1:0] valid_q;
  logic [PageCount-1:0] dirty_q;
  logic [TagSize-1:0]   tag_q [PageCount];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < PageCount; i++) tag_q[i] <= '0;
    end else if (invalidateAll_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (setDirty_i) dirty_q[lookupIndex_i] <= 1'b1;
      if (clearDirty_i) dirty_q[pageIndex_i] <= 1'b0;
      if (fill_i) begin
        tag_q[pageIndex_i]   <= fillTag_i;
        valid_q[pageIndex_i] <= 1'b1;
        dirty_q[pageIndex_i] <= 1'b0;
      end
    end
  end

  assign lookupMatch_o = valid_q[lookupIndex_i] && (tag_q[lookupIndex_i] == lookupTag_i);
  assign lookupDirty_o = valid_q[lookupIndex_i] && dirty_q[lookupIndex_i];
  assign pageDirty_o   = valid_q[pageIndex_i] && dirty_q[pageIndex_i];
  assign pageTag_o     = tag_q[pageIndex_i];

endmodule

// File: rtl/paged_cache_controller.sv
// Direct-mapped paged cache in front of a QSPI word-stream device, with write-back eviction,
// flush-all scan, invalidate-all and a miss counter.
module paged_cache_controller
  import paged_cache_controller_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE            = 24,
  parameter int unsigned SRAM_ADDRESS_SIZE       = 9,
  parameter int unsigned PAGE_INDEX_ADDRESS_SIZE = 4,
  parameter int unsigned WRITE_BACK              = 1,
  parameter int unsigned MISS_COUNT_SIZE         = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         bus_enable,
  input  logic                         bus_write_enable,
  input  logic [ADDRESS_SIZE-1:0]      bus_address,
  output logic                         bus_ready,
  output logic                         bus_error,
  output logic [SRAM_ADDRESS_SIZE-1:0] bus_physical_address,
  input  logic                         flush_all,
  input  logic                         invalidate_all,
  output logic                         busy,
  output logic [MISS_COUNT_SIZE-1:0]   miss_count,
  input  logic                         mem_initialised,
  input  logic                         mem_busy,
  input  logic                         mem_word_complete,
  output logic [ADDRESS_SIZE-1:0]      mem_address,
  output logic                         mem_change_address,
  output logic                         mem_request_data,
  output logic                         mem_store_data,
  output logic                         sram_enable,
  output logic                         sram_write_enable,
  output logic [SRAM_ADDRESS_SIZE-1:0] sram_address
);

  localparam int unsigned TagSize      = tagSize(ADDRESS_SIZE, SRAM_ADDRESS_SIZE);
  localparam int unsigned PageDataSize = pageDataAddressSize(SRAM_ADDRESS_SIZE,
                                                             PAGE_INDEX_ADDRESS_SIZE);
  localparam int unsigned IndexSize    = PAGE_INDEX_ADDRESS_SIZE;

  cacheState_t state_q, state_d;
  logic [IndexSize-1:0]       pageIndex_q, pageIndex_d;
  logic [TagSize-1:0]         newTag_q, newTag_d;
  logic [PageDataSize-1:0]    wordCount_q, wordCount_d;
  logic                       flushPending_q, flushPending_d;
  logic                       invalidatePending_q, invalidatePending_d;
  logic                       scanMode_q, scanMode_d;
  logic [MISS_COUNT_SIZE-1:0] missCount_q, missCount_d;

  logic [TagSize-1:0]   busTag, pageTag;
  logic [IndexSize-1:0] busIndex;
  logic lookupMatch, lookupDirty, pageDirty;
  logic setDirty, clearDirty, fill, invalidate;
  logic flushReq, invalidateReq, rejectWrite, hitNow, memReady, lastWord;
  logic unusedByteOffset;

  assign busTag               = bus_address[ADDRESS_SIZE-1 -: TagSize];
  assign busIndex             = bus_address[SRAM_ADDRESS_SIZE+1 -: IndexSize];
  assign bus_physical_address = bus_address[SRAM_ADDRESS_SIZE+1:2];
  assign unusedByteOffset     = ^bus_address[1:0];

  // A flush/invalidate pulse arriving this cycle blocks hits just like a latched one.
  assign flushReq      = flushPending_q | flush_all;
  assign invalidateReq = invalidatePending_q | invalidate_all;
  assign rejectWrite   = bus_write_enable && (WRITE_BACK == 0);
  assign hitNow        = (state_q == StIdle) && !flushReq && !invalidateReq && lookupMatch;
  assign memReady      = mem_initialised && !mem_busy;
  assign lastWord      = (wordCount_q == '1);

  assign bus_ready  = bus_enable && !rejectWrite && hitNow;
  assign bus_error  = bus_enable && rejectWrite;
  assign busy       = (state_q != StIdle) || flushPending_q || invalidatePending_q;
  assign miss_count = missCount_q;

  cache_tag_store #(
    .TagSize  (TagSize),
    .IndexSize(IndexSize)
  ) u_tagStore (
    .clk_i          (wb_clk_i),
    .rst_ni         (wb_rst_i),
    .lookupIndex_i  (busIndex),
    .lookupTag_i    (busTag),
    .lookupMatch_o  (lookupMatch),
    .lookupDirty_o  (lookupDirty),
    .pageIndex_i    (pageIndex_q),
    .pageDirty_o    (pageDirty),
    .pageTag_o      (pageTag),
    .setDirty_i     (setDirty),
    .clearDirty_i   (clearDirty),
    .fill_i         (fill),
    .fillTag_i      (newTag_q),
    .invalidateAll_i(invalidate)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q             <= StIdle;
      pageIndex_q         <= '0;
      newTag_q            <= '0;
      wordCount_q         <= '0;
      flushPending_q      <= 1'b0;
      invalidatePending_q <= 1'b0;
      scanMode_q          <= 1'b0;
      missCount_q         <= '0;
    end else begin
      state_q             <= state_d;
      pageIndex_q         <= pageIndex_d;
      newTag_q            <= newTag_d;
      wordCount_q         <= wordCount_d;
      flushPending_q      <= flushPending_d;
      invalidatePending_q <= invalidatePending_d;
      scanMode_q          <= scanMode_d;
      missCount_q         <= missCount_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pageIndex_d         = pageIndex_q;
    newTag_d            = newTag_q;
    wordCount_d         = wordCount_q;
    flushPending_d      = flushReq;
    invalidatePending_d = invalidateReq;
    scanMode_d          = scanMode_q;
    missCount_d         = missCount_q;
    unique case (state_q)
      StIdle: begin
        if (flushReq) begin
          state_d        = StScan;
          pageIndex_d    = '0;
          scanMode_d     = 1'b1;
          flushPending_d = 1'b0;
        end else if (invalidateReq) begin
          invalidatePending_d = 1'b0;
        end else if (bus_enable && !rejectWrite && !lookupMatch) begin
          pageIndex_d = busIndex;
          newTag_d    = busTag;
          missCount_d = missCount_q + 1'b1;
          scanMode_d  = 1'b0;
          state_d     = lookupDirty ? StFlushStart : StLoadStart;
        end
      end
      StScan: begin
        if (pageDirty) state_d = StFlushStart;
        else if (pageIndex_q == '1) state_d = StIdle;
        else pageIndex_d = pageIndex_q + 1'b1;
      end
      StFlushStart: begin
        if (memReady) begin
          wordCount_d = '0;
          state_d     = StFlushRead;
        end
      end
      StFlushRead: state_d = StFlushWord;
      StFlushWord: begin
        if (mem_word_complete) begin
          wordCount_d = wordCount_q + 1'b1;
          // The scan revisits the just-cleaned page and moves on from there.
          if (lastWord) state_d = scanMode_q ? StScan : StLoadStart;
          else state_d = StFlushRead;
        end
      end
      StLoadStart: begin
        if (memReady) begin
          wordCount_d = '0;
          state_d     = StLoadWord;
        end
      end
      StLoadWord: begin
        if (mem_word_complete) begin
          wordCount_d = wordCount_q + 1'b1;
          if (lastWord) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_address        = '0;
    mem_change_address = 1'b0;
    mem_request_data   = 1'b0;
    mem_store_data     = 1'b0;
    sram_enable        = 1'b0;
    sram_write_enable  = 1'b0;
    sram_address       = '0;
    setDirty           = 1'b0;
    clearDirty         = 1'b0;
    fill               = 1'b0;
    invalidate         = 1'b0;
    unique case (state_q)
      StIdle: begin
        setDirty   = bus_enable && bus_write_enable && hitNow && (WRITE_BACK != 0);
        invalidate = !flushReq && invalidateReq;
      end
      StFlushStart: begin
        mem_address        = {pageTag, pageIndex_q, {(PageDataSize + 2){1'b0}}};
        mem_change_address = memReady;
      end
      StFlushRead: begin
        sram_enable  = 1'b1;
        sram_address = {pageIndex_q, wordCount_q};
      end
      StFlushWord: begin
        sram_enable    = 1'b1;
        sram_address   = {pageIndex_q, wordCount_q};
        mem_store_data = 1'b1;
        clearDirty     = mem_word_complete && lastWord;
      end
      StLoadStart: begin
        mem_address        = {newTag_q, pageIndex_q, {(PageDataSize + 2){1'b0}}};
        mem_change_address = memReady;
      end
      StLoadWord: begin
        mem_request_data  = 1'b1;
        sram_enable       = mem_word_complete;
        sram_write_enable = mem_word_complete;
        sram_address      = {pageIndex_q, wordCount_q};
        fill              = mem_word_complete && lastWord;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_paged_cache_controller.sv
// Scoreboard bench: expected QSPI page transfers are queued with each access and matched as
// the memory responder completes them.
module tb_paged_cache_controller;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        busEnable, busWrite, roEnable;
  logic [23:0] busAddress;
  logic        flushAll, invalidateAll, memInit, memBusy, memWordComplete;

  logic        busReady, busError, busy, memChange, memRequest, memStore, sramEnable, sramWe;
  logic [8:0]  busPhys, sramAddress;
  logic [15:0] missCount;
  logic [23:0] memAddress;

  logic        roReady, roError, roBusy, roMemChange, roMemRequest, roMemStore;
  logic        roSramEnable, roSramWe;
  logic [8:0]  roPhys, roSramAddress;
  logic [15:0] roMissCount;
  logic [23:0] roMemAddress;

  always #5 clk = ~clk;

  paged_cache_controller #(.WRITE_BACK(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rstN),
    .bus_enable(busEnable), .bus_write_enable(busWrite), .bus_address(busAddress),
    .bus_ready(busReady), .bus_error(busError), .bus_physical_address(busPhys),
    .flush_all(flushAll), .invalidate_all(invalidateAll), .busy(busy), .miss_count(missCount),
    .mem_initialised(memInit), .mem_busy(memBusy), .mem_word_complete(memWordComplete),
    .mem_address(memAddress), .mem_change_address(memChange),
    .mem_request_data(memRequest), .mem_store_data(memStore),
    .sram_enable(sramEnable), .sram_write_enable(sramWe), .sram_address(sramAddress)
  );

  paged_cache_controller #(.WRITE_BACK(0)) dutRo (
    .wb_clk_i(clk), .wb_rst_i(rstN),
    .bus_enable(roEnable), .bus_write_enable(busWrite), .bus_address(busAddress),
    .bus_ready(roReady), .bus_error(roError), .bus_physical_address(roPhys),
    .flush_all(1'b0), .invalidate_all(1'b0), .busy(roBusy), .miss_count(roMissCount),
    .mem_initialised(memInit), .mem_busy(memBusy), .mem_word_complete(1'b0),
    .mem_address(roMemAddress), .mem_change_address(roMemChange),
    .mem_request_data(roMemRequest), .mem_store_data(roMemStore),
    .sram_enable(roSramEnable), .sram_write_enable(roSramWe), .sram_address(roSramAddress)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {isLoad, page base byte address}.
  logic [24:0] expQ[$];

  task automatic expectXfer(input logic isLoad, input logic [23:0] base);
    expQ.push_back({isLoad, base});
  endtask

  // Memory responder: completes each requested word after three cycles.
  int memWait = 0;
  initial begin
    memWordComplete = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN || memWordComplete) begin
        memWordComplete = 1'b0;
        memWait = 0;
      end else if (memRequest || memStore) begin
        if (memWait == 2) begin
          memWordComplete = 1'b1;
          memWait = 0;
        end else memWait++;
      end else memWait = 0;
    end
  end

  // Transfer monitor, sampling on the falling edge.
  logic [23:0] curBase;
  logic [24:0] expEntry;
  int stores = 0, loads = 0, sramBad = 0, xferDone = 0, changeCount = 0, roChanges = 0;
  bit active = 1'b0;
  always @(negedge clk) begin
    if (!rstN) begin
      active = 1'b0;
      stores = 0;
      loads = 0;
      sramBad = 0;
    end else begin
      if (roMemChange) roChanges++;
      if (memChange) begin
        active = 1'b1;
        curBase = memAddress;
        stores = 0;
        loads = 0;
        sramBad = 0;
        changeCount++;
      end else if (active && memWordComplete && memStore) begin
        if (!(sramEnable && !sramWe && sramAddress == {curBase[10:7], 5'(stores)})) sramBad++;
        stores++;
      end else if (active && memWordComplete && memRequest) begin
        if (!(sramEnable && sramWe && sramAddress == {curBase[10:7], 5'(loads)})) sramBad++;
        loads++;
      end
      if (active && (stores == 32 || loads == 32)) begin
        active = 1'b0;
        xferDone++;
        checkVal("xferQueued", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          expEntry = expQ.pop_front();
          checkVal("xfer", {loads == 32, curBase}, expEntry);
          checkVal("xferSram", sramBad, 0);
        end
      end
    end
  end

  task automatic startAccess(input logic [23:0] addr, input logic write);
    busAddress = addr;
    busWrite   = write;
    busEnable  = 1'b1;
  endtask

  task automatic waitAccess(output int lat, output logic [8:0] phys, output logic err);
    lat = 0;
    phys = '0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (busReady || busError) begin
        phys = busPhys;
        err  = busError;
        break;
      end
      lat++;
      if (lat > 3000) begin
        checkVal("accessTimeout", 32'(lat), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    busEnable = 1'b0;
    busWrite  = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [8:0] phys;
    logic err;
    int doneBefore, chBefore;
    logic sawReady;
    busEnable = 0; busWrite = 0; busAddress = 24'h001234; roEnable = 0;
    flushAll = 0; invalidateAll = 0; memInit = 1; memBusy = 0;
    rstN = 0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstBusy", busy, 0);
    checkVal("rstMissCount", missCount, 0);
    checkVal("rstSramEnable", sramEnable, 0);
    checkVal("rstMemChange", memChange, 0);
    checkVal("rstPhys", busPhys, 9'h08D);
    rstN = 1;
    @(posedge clk);
    #1;

    // Cold read miss on page 2.
    expectXfer(1, 24'h000100);
    startAccess(24'h000100, 0);
    waitAccess(lat, phys, err);
    checkVal("t1Missed", 32'(lat > 0), 1);
    checkVal("t1Err", err, 0);
    checkVal("t1Phys", phys, 9'h040);
    checkVal("t1MissCount", missCount, 1);
    checkVal("t1Queue", expQ.size(), 0);

    // Read-only instance rejects writes without touching memory.
    busAddress = 24'h000100; busWrite = 1; roEnable = 1;
    @(negedge clk);
    checkVal("t3Error", roError, 1);
    checkVal("t3Ready", roReady, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("t3Busy", roBusy, 0);
    checkVal("t3MissCount", roMissCount, 0);
    checkVal("t3Change", roChanges, 0);
    @(posedge clk);
    #1;
    roEnable = 0; busWrite = 0;

    // Write hit dirties page 2, then a conflicting read evicts it.
    startAccess(24'h000104, 1);
    waitAccess(lat, phys, err);
    checkVal("t2WriteLat", lat, 0);
    checkVal("t2WriteErr", err, 0);
    checkVal("t2WritePhys", phys, 9'h041);
    expectXfer(0, 24'h000100);
    expectXfer(1, 24'h000900);
    startAccess(24'h000904, 0);
    waitAccess(lat, phys, err);
    checkVal("t2ReadPhys", phys, 9'h041);
    checkVal("t2MissCount", missCount, 2);
    checkVal("t2Queue", expQ.size(), 0);

    // Dirty pages 3 and 7, then flush_all and invalidate_all.
    expectXfer(1, 24'h000180);
    startAccess(24'h000180, 0);
    waitAccess(lat, phys, err);
    expectXfer(1, 24'h000380);
    startAccess(24'h000380, 0);
    waitAccess(lat, phys, err);
    startAccess(24'h000184, 1);
    waitAccess(lat, phys, err);
    checkVal("t4Write3Lat", lat, 0);
    startAccess(24'h000384, 1);
    waitAccess(lat, phys, err);
    checkVal("t4Write7Lat", lat, 0);
    expectXfer(0, 24'h000180);
    expectXfer(0, 24'h000380);
    doneBefore = xferDone;
    flushAll = 1;
    @(posedge clk);
    #1;
    flushAll = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkVal("t4FlushCount", xferDone - doneBefore, 2);
    checkVal("t4BusyEnd", busy, 0);
    @(posedge clk);
    #1;
    startAccess(24'h000180, 0);
    waitAccess(lat, phys, err);
    checkVal("t4Hit3Lat", lat, 0);
    startAccess(24'h000380, 0);
    waitAccess(lat, phys, err);
    checkVal("t4Hit7Lat", lat, 0);
    checkVal("t4MissCount", missCount, 4);
    invalidateAll = 1;
    @(posedge clk);
    #1;
    invalidateAll = 0;
    expectXfer(1, 24'h000180);
    startAccess(24'h000180, 0);
    waitAccess(lat, phys, err);
    checkVal("t4InvMissed", 32'(lat > 0), 1);
    checkVal("t4InvMissCount", missCount, 5);

    // Miss while the QSPI device is not yet initialised.
    memInit = 0;
    chBefore = changeCount;
    expectXfer(1, 24'h002080);
    startAccess(24'h002080, 0);
    sawReady = 0;
    repeat (15) begin
      @(negedge clk);
      sawReady = sawReady | busReady;
    end
    checkVal("t6NoReady", sawReady, 0);
    checkVal("t6NoChange", changeCount - chBefore, 0);
    checkVal("t6Busy", busy, 1);
    @(posedge clk);
    #1;
    memInit = 1;
    waitAccess(lat, phys, err);
    checkVal("t6Phys", phys, 9'h020);
    checkVal("t6MissCount", missCount, 6);
    checkVal("t6Queue", expQ.size(), 0);

    // Reset in the middle of a page load.
    chBefore = changeCount;
    startAccess(24'h001000, 0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (changeCount > chBefore && loads >= 10) break;
    end
    checkVal("t5Reached", 32'(changeCount > chBefore && loads >= 10), 1);
    rstN = 0;
    busEnable = 0;
    #1;
    checkVal("t5MemRequest", memRequest, 0);
    checkVal("t5SramEnable", sramEnable, 0);
    checkVal("t5Busy", busy, 0);
    checkVal("t5MissCount", missCount, 0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1;
    @(posedge clk);
    #1;
    expectXfer(1, 24'h001000);
    startAccess(24'h001000, 0);
    waitAccess(lat, phys, err);
    checkVal("t5ReloadMissed", 32'(lat > 0), 1);
    checkVal("t5Phys", phys, 9'h000);
    checkVal("t5ReloadMissCount", missCount, 1);

    repeat (2) @(posedge clk);
    checkVal("sbEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
